// File: rtl/opb_master_pkg.sv
// Shared types and constants for the single-beat OPB register master.
package opb_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        RSP  = 2'd3
    } state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_ERR     = 2'd1;
    localparam logic [1:0] ST_RETRY   = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    localparam int BE_W = 4;

endpackage

// File: rtl/opb_register_master_if.sv
// Command/response handshake and OPB master-side signals of the register master.
interface opb_register_master_if
    import opb_master_pkg::*;
#(
    parameter int C_OPB_AWIDTH = 32,
    parameter int C_OPB_DWIDTH = 32
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_rnw;
    logic [0:C_OPB_AWIDTH-1] cmd_addr;
    logic [0:BE_W-1]         cmd_be;
    logic [0:C_OPB_DWIDTH-1] cmd_data;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [0:C_OPB_DWIDTH-1] rsp_data;
    logic [1:0]              rsp_status;

    logic                    M_request;
    logic                    M_select;
    logic                    M_RNW;
    logic                    M_seqAddr;
    logic                    M_busLock;
    logic [0:C_OPB_AWIDTH-1] M_ABus;
    logic [0:BE_W-1]         M_BE;
    logic [0:C_OPB_DWIDTH-1] M_DBus;
    logic                    OPB_MGrant;
    logic                    OPB_xferAck;
    logic                    OPB_errAck;
    logic                    OPB_retry;
    logic                    OPB_toutSup;
    logic [0:C_OPB_DWIDTH-1] OPB_DBus;

    modport master (
        input  cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_data, rsp_ready,
               OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup, OPB_DBus,
        output cmd_ready, rsp_valid, rsp_data, rsp_status,
               M_request, M_select, M_RNW, M_seqAddr, M_busLock, M_ABus, M_BE, M_DBus
    );

    modport slave (
        output cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_data, rsp_ready,
               OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup, OPB_DBus,
        input  cmd_ready, rsp_valid, rsp_data, rsp_status,
               M_request, M_select, M_RNW, M_seqAddr, M_busLock, M_ABus, M_BE, M_DBus
    );

endinterface

// File: rtl/opb_register_master.sv
// Single-beat OPB master: one command in, arbitrate, one transfer, one response out.
// Every output is a flop loaded from the next state, so no OPB input reaches an OPB output.
module opb_register_master
    import opb_master_pkg::*;
#(
    parameter int C_OPB_AWIDTH = 32,
    parameter int C_OPB_DWIDTH = 32,
    parameter int C_MAX_RETRY  = 3,
    parameter int C_TIMEOUT    = 16
) (
    input logic                   OPB_Clk,
    input logic                   OPB_Rst_n,
    opb_register_master_if.master bus
);

    state_t state_q, state_d;

    logic                    rnw_q;
    logic [0:C_OPB_AWIDTH-1] addr_q;
    logic [0:BE_W-1]         be_q;
    logic [0:C_OPB_DWIDTH-1] data_q;
    logic [7:0]              retry_cnt, tout_cnt;
    logic [0:C_OPB_DWIDTH-1] rsp_data_q;
    logic [1:0]              rsp_status_q;

    logic       accept, retry_inc, tout_inc, set_rsp, capture;
    logic [1:0] status_d;

    logic                    cmd_ready_q, rsp_valid_q, m_request_q, m_select_q, m_rnw_q;
    logic [0:C_OPB_AWIDTH-1] m_abus_q;
    logic [0:BE_W-1]         m_be_q;
    logic [0:C_OPB_DWIDTH-1] m_dbus_q;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        retry_inc = 1'b0;
        tout_inc  = 1'b0;
        set_rsp   = 1'b0;
        capture   = 1'b0;
        status_d  = ST_OK;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                accept  = 1'b1;
                state_d = REQ;
            end
            REQ: if (bus.OPB_MGrant) state_d = XFER;
            XFER: begin
                if (bus.OPB_errAck) begin
                    set_rsp  = 1'b1;
                    status_d = ST_ERR;
                    state_d  = RSP;
                end else if (bus.OPB_xferAck) begin
                    set_rsp  = 1'b1;
                    capture  = rnw_q;
                    state_d  = RSP;
                end else if (bus.OPB_retry) begin
                    if (retry_cnt < 8'(C_MAX_RETRY)) begin
                        retry_inc = 1'b1;
                        state_d   = REQ;
                    end else begin
                        set_rsp  = 1'b1;
                        status_d = ST_RETRY;
                        state_d  = RSP;
                    end
                end else if (!bus.OPB_toutSup) begin
                    if (tout_cnt == 8'(C_TIMEOUT - 1)) begin
                        set_rsp  = 1'b1;
                        status_d = ST_TIMEOUT;
                        state_d  = RSP;
                    end else begin
                        tout_inc = 1'b1;
                    end
                end
            end
            RSP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            rnw_q        <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            data_q       <= '0;
            retry_cnt    <= '0;
            tout_cnt     <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            if (accept) begin
                rnw_q     <= bus.cmd_rnw;
                addr_q    <= bus.cmd_addr;
                be_q      <= bus.cmd_be;
                data_q    <= bus.cmd_data;
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + 8'd1;
            end
            // Cleared whenever outside XFER so every (re)entry starts from zero
            if (state_q != XFER) tout_cnt <= '0;
            else if (tout_inc)   tout_cnt <= tout_cnt + 8'd1;
            if (set_rsp) begin
                rsp_status_q <= status_d;
                rsp_data_q   <= capture ? bus.OPB_DBus : '0;
            end
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            m_request_q <= 1'b0;
            m_select_q  <= 1'b0;
            m_rnw_q     <= 1'b0;
            m_abus_q    <= '0;
            m_be_q      <= '0;
            m_dbus_q    <= '0;
        end else begin
            cmd_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RSP);
            m_request_q <= (state_d == REQ);
            m_select_q  <= (state_d == XFER);
            m_rnw_q     <= (state_d == XFER) && rnw_q;
            m_abus_q    <= (state_d == XFER) ? addr_q : '0;
            m_be_q      <= (state_d == XFER) ? be_q : '0;
            m_dbus_q    <= (state_d == XFER && !rnw_q) ? data_q : '0;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_status = rsp_status_q;
    assign bus.M_request  = m_request_q;
    assign bus.M_select   = m_select_q;
    assign bus.M_RNW      = m_rnw_q;
    assign bus.M_ABus     = m_abus_q;
    assign bus.M_BE       = m_be_q;
    assign bus.M_DBus     = m_dbus_q;
    assign bus.M_seqAddr  = 1'b0;
    assign bus.M_busLock  = 1'b0;

endmodule

// File: tb/tb_opb_register_master.sv
// Directed bench for opb_register_master: scripted OPB slave, hand-computed expectations.
module tb_opb_register_master;
    import opb_master_pkg::*;

    logic OPB_Clk   = 1'b0;
    logic OPB_Rst_n = 1'b0;
    int   checks    = 0;
    int   errors    = 0;

    opb_register_master_if bus ();

    opb_register_master dut (
        .OPB_Clk  (OPB_Clk),
        .OPB_Rst_n(OPB_Rst_n),
        .bus      (bus)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge OPB_Clk);
        #1;
    endtask

    task automatic send(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] data);
        chk("cmd_ready before send", bus.cmd_ready, 1);
        bus.cmd_rnw   = rnw;
        bus.cmd_addr  = addr;
        bus.cmd_be    = be;
        bus.cmd_data  = data;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_sel(input string tag);
        int n = 0;
        while (!bus.M_select && n < 40) begin
            tick();
            n++;
        end
        chk(tag, bus.M_select, 1);
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("rsp_valid drop", bus.rsp_valid, 0);
        chk("cmd_ready back", bus.cmd_ready, 1);
    endtask

    task automatic outs_idle(input string tag);
        chk(tag, {bus.M_request, bus.M_select, bus.M_RNW, bus.M_seqAddr, bus.M_busLock,
                  bus.M_BE, bus.rsp_valid, bus.cmd_ready}, 11'b0000_0_0000_0_1);
        chk({tag, " abus"}, bus.M_ABus, 0);
        chk({tag, " dbus"}, bus.M_DBus, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs;
        logic prev_req;
        bus.cmd_valid = 0; bus.cmd_rnw = 0; bus.cmd_addr = '0; bus.cmd_be = '0;
        bus.cmd_data = '0; bus.rsp_ready = 0; bus.OPB_MGrant = 0; bus.OPB_xferAck = 0;
        bus.OPB_errAck = 0; bus.OPB_retry = 0; bus.OPB_toutSup = 0; bus.OPB_DBus = '0;

        #12;
        outs_idle("reset state");
        tick();
        OPB_Rst_n = 1'b1;
        tick();
        outs_idle("after release");

        // Write, immediate grant, ack in first XFER cycle
        bus.OPB_MGrant = 1'b1;
        send(0, 32'h0100_8000, 4'hF, 32'hDEAD_BEEF);
        chk("w c1 req", {bus.M_request, bus.M_select, bus.cmd_ready}, 3'b100);
        chk("w c1 abus", bus.M_ABus, 0);
        tick();
        chk("w c2 sel", {bus.M_request, bus.M_select, bus.M_RNW}, 3'b010);
        chk("w c2 abus", bus.M_ABus, 32'h0100_8000);
        chk("w c2 dbus", bus.M_DBus, 32'hDEAD_BEEF);
        chk("w c2 be", bus.M_BE, 4'hF);
        bus.OPB_xferAck = 1'b1;
        tick();
        bus.OPB_xferAck = 1'b0;
        chk("w c3 rsp", {bus.rsp_valid, bus.rsp_status, bus.M_select}, {1'b1, ST_OK, 1'b0});
        chk("w c3 data", bus.rsp_data, 0);
        chk("w c3 abus", bus.M_ABus, 0);
        chk("w c3 dbus", bus.M_DBus, 0);
        finish_rsp();

        // Read with grant delayed 5 cycles
        bus.OPB_MGrant = 1'b0;
        send(1, 32'h0100_8004, 4'hF, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            chk("r wait req", {bus.M_request, bus.M_select}, 2'b10);
            chk("r wait dbus", bus.M_DBus, 0);
            tick();
        end
        bus.OPB_MGrant = 1'b1;
        tick();
        chk("r sel", {bus.M_request, bus.M_select, bus.M_RNW}, 3'b011);
        chk("r abus", bus.M_ABus, 32'h0100_8004);
        chk("r dbus", bus.M_DBus, 0);
        bus.OPB_DBus    = 32'h1234_5678;
        bus.OPB_xferAck = 1'b1;
        tick();
        bus.OPB_xferAck = 1'b0;
        bus.OPB_DBus    = '0;
        chk("r rsp", {bus.rsp_valid, bus.rsp_status}, {1'b1, ST_OK});
        chk("r data", bus.rsp_data, 32'h1234_5678);
        finish_rsp();

        // Four retries against a limit of three
        reqs = 0;
        send(0, 32'h0000_0010, 4'h3, 32'h0000_00AA);
        for (int k = 0; k < 4; k++) begin
            wait_sel("retry sel");
            chk("retry no req", bus.M_request, 0);
            bus.OPB_retry = 1'b1;
            tick();
            bus.OPB_retry = 1'b0;
            if (k < 3) begin
                chk("retry gap", {bus.M_select, bus.M_request}, 2'b01);
                reqs++;
            end
        end
        chk("retry count", reqs, 3);
        chk("retry rsp", {bus.rsp_valid, bus.rsp_status, bus.M_select}, {1'b1, ST_RETRY, 1'b0});
        chk("retry data", bus.rsp_data, 0);
        finish_rsp();

        // Timeout after 16 unacknowledged XFER cycles
        send(1, 32'h0000_0020, 4'hF, 32'h0);
        wait_sel("tout sel");
        for (int i = 0; i < 15; i++) tick();
        chk("tout edge", {bus.M_select, bus.rsp_valid}, 2'b10);
        tick();
        chk("tout rsp", {bus.rsp_valid, bus.rsp_status, bus.M_select}, {1'b1, ST_TIMEOUT, 1'b0});
        chk("tout data", bus.rsp_data, 0);
        finish_rsp();

        // toutSup holds the counter for 20 cycles, then ack
        send(1, 32'h0000_0024, 4'hF, 32'h0);
        wait_sel("sup sel");
        bus.OPB_toutSup = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("sup hold", {bus.M_select, bus.rsp_valid}, 2'b10);
        bus.OPB_toutSup = 1'b0;
        bus.OPB_xferAck = 1'b1;
        bus.OPB_DBus    = 32'hA5A5_0F0F;
        tick();
        bus.OPB_xferAck = 1'b0;
        bus.OPB_DBus    = '0;
        chk("sup rsp", {bus.rsp_valid, bus.rsp_status}, {1'b1, ST_OK});
        chk("sup data", bus.rsp_data, 32'hA5A5_0F0F);
        finish_rsp();

        // errAck wins over a simultaneous xferAck
        send(1, 32'h0000_0028, 4'hF, 32'h0);
        wait_sel("err sel");
        bus.OPB_errAck  = 1'b1;
        bus.OPB_xferAck = 1'b1;
        bus.OPB_DBus    = 32'hFFFF_FFFF;
        tick();
        bus.OPB_errAck  = 1'b0;
        bus.OPB_xferAck = 1'b0;
        bus.OPB_DBus    = '0;
        chk("err rsp", {bus.rsp_valid, bus.rsp_status}, {1'b1, ST_ERR});
        chk("err data", bus.rsp_data, 0);
        finish_rsp();

        // Response held for 10 cycles with rsp_ready low
        send(1, 32'h0000_0030, 4'hF, 32'h0);
        wait_sel("hold sel");
        bus.OPB_xferAck = 1'b1;
        bus.OPB_DBus    = 32'h0BAD_F00D;
        tick();
        bus.OPB_xferAck = 1'b0;
        bus.OPB_DBus    = '0;
        for (int i = 0; i < 10; i++) begin
            chk("hold stable", {bus.rsp_valid, bus.cmd_ready, bus.rsp_status, bus.rsp_data},
                {1'b1, 1'b0, ST_OK, 32'h0BAD_F00D});
            tick();
        end
        finish_rsp();

        // Asynchronous reset in the middle of a transfer
        send(0, 32'h0000_0040, 4'hF, 32'h5555_AAAA);
        wait_sel("rst sel");
        chk("rst pre dbus", bus.M_DBus, 32'h5555_AAAA);
        #2;
        OPB_Rst_n = 1'b0;
        #1;
        outs_idle("async reset");
        tick();
        #2;
        OPB_Rst_n = 1'b1;
        prev_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            prev_req = prev_req | bus.rsp_valid | bus.M_request;
        end
        chk("no rsp after reset", prev_req, 0);
        outs_idle("idle after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
